pipe_stage_skid_reg: RTL

//   Generic pipeline stage register for the uDLX pipeline (IF/ID, ID/EX, EX/MEM, MEM/WB).

---
 rtl/udlx_pipe_pkg.sv | 16 +
 rtl/pipe_stage_slot.sv | 34 +++
 rtl/pipe_stage_skid_reg.sv | 130 +++++++++++++
 3 files changed

// File: rtl/udlx_pipe_pkg.sv
// Shared constants for the uDLX pipeline boundary registers.
// State encoding doubles as the held-beat count.
package udlx_pipe_pkg;

    typedef logic [1:0] pipe_state_t;

    localparam pipe_state_t ST_EMPTY = 2'd0;
    localparam pipe_state_t ST_FULL  = 2'd1;
    localparam pipe_state_t ST_SKID  = 2'd2;

    localparam int unsigned IF_ID_W  = 64;
    localparam int unsigned ID_EX_W  = 128;
    localparam int unsigned EX_MEM_W = 96;
    localparam int unsigned MEM_WB_W = 72;

endpackage

// File: rtl/pipe_stage_slot.sv
// Single payload register with synchronous clear (priority over load) and async reset.
module pipe_stage_slot #(
    parameter int unsigned DATA_WIDTH = 128
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_in,
    input  logic                  clear_in,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out
);

    logic [DATA_WIDTH-1:0] data_q, data_d;

    always_comb begin
        data_d = data_q;
        if (clear_in) begin
            data_d = '0;
        end else if (load_in) begin
            data_d = data_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign data_out = data_q;

endmodule

// File: rtl/pipe_stage_skid_reg.sv
// Pipeline boundary register with valid/ready handshake and synchronous flush.
// Define PIPE_STAGE_SKID_EN to add the skid slot and a fully registered up_ready_out.
module pipe_stage_skid_reg
    import udlx_pipe_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 128,
    parameter bit          CLEAR_ON_EMPTY = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush_in,
    input  logic                  up_valid_in,
    output logic                  up_ready_out,
    input  logic [DATA_WIDTH-1:0] up_data_in,
    output logic                  dn_valid_out,
    input  logic                  dn_ready_in,
    output logic [DATA_WIDTH-1:0] dn_data_out,
    output logic [1:0]            occupancy_out
);

    pipe_state_t           state_q, state_d;
    logic                  accept, emit;
    logic                  main_load, main_clear;
    logic [DATA_WIDTH-1:0] main_src;
`ifdef PIPE_STAGE_SKID_EN
    logic                  skid_load, skid_clear;
    logic [DATA_WIDTH-1:0] skid_data;
`endif

    assign dn_valid_out  = (state_q != ST_EMPTY);
    assign occupancy_out = state_q;
`ifdef PIPE_STAGE_SKID_EN
    assign up_ready_out  = (state_q != ST_SKID);
`else
    // Without a skid slot the stage can only refill when the held beat leaves this cycle.
    assign up_ready_out  = !dn_valid_out || dn_ready_in;
`endif
    assign accept = up_valid_in && up_ready_out;
    assign emit   = dn_valid_out && dn_ready_in;

    always_comb begin
        state_d    = state_q;
        main_load  = 1'b0;
        main_clear = 1'b0;
        main_src   = up_data_in;
`ifdef PIPE_STAGE_SKID_EN
        skid_load  = 1'b0;
        skid_clear = 1'b0;
`endif
        if (flush_in) begin
            state_d    = ST_EMPTY;
            main_clear = 1'b1;
`ifdef PIPE_STAGE_SKID_EN
            skid_clear = 1'b1;
`endif
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        state_d   = ST_FULL;
                        main_load = 1'b1;
                    end
                end
                ST_FULL: begin
                    if (accept && emit) begin
                        main_load = 1'b1;
`ifdef PIPE_STAGE_SKID_EN
                    end else if (accept) begin
                        state_d   = ST_SKID;
                        skid_load = 1'b1;
`endif
                    end else if (emit) begin
                        state_d    = ST_EMPTY;
                        main_clear = CLEAR_ON_EMPTY;
                    end
                end
`ifdef PIPE_STAGE_SKID_EN
                ST_SKID: begin
                    if (emit) begin
                        state_d    = ST_FULL;
                        main_load  = 1'b1;
                        main_src   = skid_data;
                        skid_clear = 1'b1;
                    end
                end
`endif
                default: begin
                    state_d    = ST_EMPTY;
                    main_clear = 1'b1;
`ifdef PIPE_STAGE_SKID_EN
                    skid_clear = 1'b1;
`endif
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    pipe_stage_slot #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_main_slot (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_in  (main_load),
        .clear_in (main_clear),
        .data_in  (main_src),
        .data_out (dn_data_out)
    );

`ifdef PIPE_STAGE_SKID_EN
    pipe_stage_slot #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid_slot (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_in  (skid_load),
        .clear_in (skid_clear),
        .data_in  (up_data_in),
        .data_out (skid_data)
    );
`endif

endmodule
